// File: rtl/c3aibadapt_cmn_occ_pkg.sv
// Shared definitions for the OCC burst controller: FSM states, Gray helper
// and the phase counter width.
package c3aibadapt_cmn_occ_pkg;

    localparam int PHASE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TRIG,
        WAIT,
        HOLD,
        DONE
    } occ_state_t;

    function automatic logic [1:0] bin2gray(input logic [1:0] bin);
        return {bin[1], bin[1] ^ bin[0]};
    endfunction

endpackage

// File: rtl/c3aibadapt_cmn_occ_burst_ctrl.sv
// Initiating side of the OCC enable handshake: sequences one at-speed capture
// per accepted request and confirms the returned clock-enable pulse count.
module c3aibadapt_cmn_occ_burst_ctrl
    import c3aibadapt_cmn_occ_pkg::*;
#(
    parameter int SETUP_CYC = 6,
    parameter int TRIG_CYC  = 2,
    parameter int HOLD_CYC  = 4,
    parameter int WAIT_MAX  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] burst_len,
    input  logic       atpg_mode,
    input  logic       clken_obs,
    output logic       scan_enable,
    output logic       occ_enable,
    output logic [1:0] burst_cnt,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(SETUP_CYC - 1);
    localparam logic [PHASE_W-1:0] TRIG_LAST  = PHASE_W'(TRIG_CYC - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(HOLD_CYC - 1);
    localparam logic [PHASE_W-1:0] WAIT_LAST  = PHASE_W'(WAIT_MAX - 1);

    occ_state_t         state;
    occ_state_t         state_nxt;
    logic [PHASE_W-1:0] phase;
    logic [1:0]         len_q;
    logic [1:0]         pulse_cnt;
    logic [1:0]         pulse_sum;
    logic               accept;
    logic               in_seq;
    logic               err_set;

    // Pulses seen in TRIG already count, so the WAIT exit test uses the
    // running total including this cycle's sample.
    always_comb begin
        pulse_sum = (clken_obs && pulse_cnt != 2'd3) ? pulse_cnt + 2'd1 : pulse_cnt;
        in_seq    = (state == SETUP) || (state == TRIG) || (state == WAIT) || (state == HOLD);
        accept    = (state == IDLE) && start && atpg_mode;
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (phase == SETUP_LAST) state_nxt = TRIG;
            TRIG:    if (phase == TRIG_LAST) state_nxt = (len_q == 2'd0) ? HOLD : WAIT;
            WAIT: begin
                if (pulse_sum == len_q) begin
                    state_nxt = HOLD;
                end else if (phase == WAIT_LAST) begin
                    state_nxt = HOLD;
                    err_set   = 1'b1;
                end
            end
            HOLD: begin
                if (clken_obs) err_set = 1'b1;
                if (phase == HOLD_LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (in_seq && !atpg_mode) begin
            state_nxt = DONE;
            err_set   = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            len_q       <= 2'd0;
            pulse_cnt   <= 2'd0;
            burst_cnt   <= 2'b00;
            scan_enable <= 1'b1;
            occ_enable  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
            if (accept) begin
                len_q     <= burst_len;
                burst_cnt <= bin2gray(burst_len);
                pulse_cnt <= 2'd0;
                err       <= 1'b0;
            end else begin
                if (state == TRIG || state == WAIT) pulse_cnt <= pulse_sum;
                if (err_set) err <= 1'b1;
            end
            scan_enable <= (state_nxt == IDLE) || (state_nxt == DONE);
            occ_enable  <= (state_nxt == TRIG);
            busy        <= (state_nxt == SETUP) || (state_nxt == TRIG) ||
                           (state_nxt == WAIT)  || (state_nxt == HOLD);
            done        <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_c3aibadapt_cmn_occ_burst_ctrl.sv
// Self-checking bench: per request, plans the whole expected output timeline
// from the receiver pulse schedule and compares it every cycle.
module tb_c3aibadapt_cmn_occ_burst_ctrl;

    localparam int SETUP_CYC = 6;
    localparam int TRIG_CYC  = 2;
    localparam int HOLD_CYC  = 4;
    localparam int WAIT_MAX  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] burst_len;
    logic       atpg_mode;
    logic       clken_obs;
    logic       scan_enable;
    logic       occ_enable;
    logic [1:0] burst_cnt;
    logic       busy;
    logic       done;
    logic       err;

    c3aibadapt_cmn_occ_burst_ctrl #(
        .SETUP_CYC(SETUP_CYC),
        .TRIG_CYC (TRIG_CYC),
        .HOLD_CYC (HOLD_CYC),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .atpg_mode  (atpg_mode),
        .clken_obs  (clken_obs),
        .scan_enable(scan_enable),
        .occ_enable (occ_enable),
        .burst_cnt  (burst_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    bit         check_en = 1'b0;
    int         cur_k = 0;
    int         dut_done_k = 0;
    int         occ_first_k = 0;
    int         occ_hi = 0;
    logic       exp_scan, exp_occ, exp_busy, exp_done, exp_err;
    logic [1:0] exp_cnt;
    logic [1:0] held_cnt;
    logic       held_err;
    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, req, cur_k, $time);
        end
    endtask

    task automatic set_idle_exp();
        exp_scan = 1'b1;
        exp_occ  = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = held_err;
        exp_cnt  = held_cnt;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("scan_enable", {7'd0, scan_enable}, {7'd0, exp_scan});
            checkOutput("occ_enable",  {7'd0, occ_enable},  {7'd0, exp_occ});
            checkOutput("busy",        {7'd0, busy},        {7'd0, exp_busy});
            checkOutput("done",        {7'd0, done},        {7'd0, exp_done});
            checkOutput("err",         {7'd0, err},         {7'd0, exp_err});
            checkOutput("burst_cnt",   {6'd0, burst_cnt},   {6'd0, exp_cnt});
            if (done === 1'b1) dut_done_k = cur_k;
            if (occ_enable === 1'b1) begin
                if (occ_hi == 0) occ_first_k = cur_k;
                occ_hi++;
            end
        end
    end

    // Cycle k is the k-th clock period after the accept edge; inputs driven
    // in cycle k are sampled at its closing edge.
    task automatic applyStimulus(input int len, input int np, input int d,
                                 input int abort_a, input bit busy_start, input int rst_at);
        bit pulse [64];
        int cnt, wait_end, hold_end, done_c, err_c, last;
        bit timed_out;
        for (int c = 0; c < 64; c++) pulse[c] = (c >= 7 + d) && (c < 7 + d + np);
        cnt = int'(pulse[7]) + int'(pulse[8]);
        wait_end = SETUP_CYC + TRIG_CYC;
        if (len > 0) begin
            for (int w = 1; w <= WAIT_MAX; w++) begin
                cnt = cnt + int'(pulse[wait_end + 1]);
                if (cnt > 3) cnt = 3;
                wait_end++;
                if (cnt == len) break;
            end
        end
        timed_out = (len > 0) && (cnt != len);
        hold_end  = wait_end + HOLD_CYC;
        done_c    = hold_end + 1;
        err_c     = 1000;
        if (timed_out) err_c = wait_end + 1;
        for (int h = hold_end; h > wait_end; h--) if (pulse[h] && h + 1 < err_c) err_c = h + 1;
        if (abort_a > 0 && abort_a <= hold_end) begin
            done_c = abort_a + 1;
            if (abort_a + 1 < err_c) err_c = abort_a + 1;
        end
        dut_done_k  = 0;
        occ_first_k = 0;
        occ_hi      = 0;
        start       = 1'b1;
        burst_len   = 2'(len);
        atpg_mode   = 1'b1;
        clken_obs   = 1'b0;
        last = (rst_at > 0) ? rst_at + 1 : done_c + 1;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            cur_k = k;
            if (rst_at > 0 && k == rst_at + 1) begin
                held_cnt = 2'b00;
                held_err = 1'b0;
                set_idle_exp();
                rst = 1'b0;
            end else if (k > done_c) begin
                held_cnt = gray_tab[len];
                held_err = (err_c <= done_c);
                set_idle_exp();
            end else begin
                exp_busy = (k < done_c);
                exp_done = (k == done_c);
                exp_scan = (k == done_c);
                exp_occ  = (k >= 7) && (k <= 8) && (k < done_c);
                exp_err  = (k >= err_c);
                exp_cnt  = gray_tab[len];
            end
            start     = busy_start && (k == 3);
            burst_len = 2'($urandom_range(0, 3));
            clken_obs = pulse[k];
            atpg_mode = !(abort_a > 0 && k >= abort_a && k <= done_c);
            if (rst_at > 0 && k == rst_at) rst = 1'b1;
        end
        start     = 1'b0;
        clken_obs = 1'b0;
        atpg_mode = 1'b1;
    endtask

    // Idle cycles; any start here comes with atpg_mode low and must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cur_k = 0;
            set_idle_exp();
            start     = 1'($urandom_range(0, 1));
            atpg_mode = start ? 1'b0 : 1'($urandom_range(0, 1));
            burst_len = 2'($urandom_range(0, 3));
        end
        start     = 1'b0;
        atpg_mode = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        burst_len = 2'd0;
        atpg_mode = 1'b1;
        clken_obs = 1'b0;
        held_cnt  = 2'b00;
        held_err  = 1'b0;
        set_idle_exp();
        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(2, 2, 4, 0, 1'b0, 0);
        checkOutput("len2_done_cycle", 8'(dut_done_k), 8'd17);
        checkOutput("len2_occ_first", 8'(occ_first_k), 8'd7);
        checkOutput("len2_occ_width", 8'(occ_hi), 8'd2);
        checkOutput("len2_burst_cnt", {6'd0, burst_cnt}, 8'b11);
        checkOutput("len2_err", {7'd0, err}, 8'd0);

        applyStimulus(3, 3, 5, 0, 1'b1, 0);
        checkOutput("len3_burst_cnt", {6'd0, burst_cnt}, 8'b10);
        checkOutput("len3_done_cycle", 8'(dut_done_k), 8'd19);
        checkOutput("len3_err", {7'd0, err}, 8'd0);

        applyStimulus(0, 0, 4, 0, 1'b0, 0);
        checkOutput("len0_done_cycle", 8'(dut_done_k), 8'd13);
        checkOutput("len0_burst_cnt", {6'd0, burst_cnt}, 8'b00);

        applyStimulus(2, 1, 4, 0, 1'b0, 0);
        checkOutput("timeout_done_cycle", 8'(dut_done_k), 8'd29);
        checkOutput("timeout_err", {7'd0, err}, 8'd1);

        applyStimulus(1, 1, 4, 0, 1'b0, 0);
        checkOutput("err_cleared", {7'd0, err}, 8'd0);

        applyStimulus(1, 2, 4, 0, 1'b0, 0);
        checkOutput("overrun_err", {7'd0, err}, 8'd1);

        applyStimulus(2, 0, 4, 0, 1'b0, 10);
        checkOutput("rst_no_done", 8'(dut_done_k), 8'd0);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);

        idle_cycles(4);
        checkOutput("noatpg_idle_busy", {7'd0, busy}, 8'd0);

        for (int t = 0; t < 40; t++) begin
            int len, np, d, ab;
            bit bs;
            len = $urandom_range(0, 3);
            np  = $urandom_range(0, 3);
            d   = $urandom_range(4, 5);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
            bs  = 1'($urandom_range(0, 1));
            applyStimulus(len, np, d, ab, bs, 0);
            idle_cycles($urandom_range(0, 2));
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
